// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: opcode, state and alu_op encodings shared by control and datapath
package multicycle_control_pkg;
  localparam logic [3:0] OP_NOP = 4'h0, OP_LOAD = 4'h1, OP_STORE = 4'h2, OP_ADD = 4'h3,
                         OP_SUB = 4'h4, OP_AND = 4'h5, OP_OR = 4'h6, OP_JMP = 4'h7,
                         OP_JZ = 4'h8, OP_HALT = 4'hF;
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_MEM_RD = 3'd2,
                         S_EXEC = 3'd3, S_MEM_WR = 3'd4, S_HALT = 3'd5;
  localparam logic [2:0] ALU_PASS_B = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2,
                         ALU_AND = 3'd3, ALU_OR = 3'd4;
  function automatic logic [2:0] alu_of(input logic [3:0] op);
    return op == OP_ADD ? ALU_ADD : op == OP_SUB ? ALU_SUB :
           op == OP_AND ? ALU_AND : op == OP_OR ? ALU_OR : ALU_PASS_B;
  endfunction
  function automatic logic reads_operand(input logic [3:0] op);
    return op inside {OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR};
  endfunction
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control <-> datapath/memory signal bundle
interface multicycle_control_if #(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 3,
  parameter int CNT_W    = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                acc_zero;
  logic                mem_ready;
  logic                mem_read;
  logic                mem_write;
  logic                addr_sel;
  logic                ir_load;
  logic                mdr_load;
  logic                pc_inc;
  logic                pc_load;
  logic                acc_load;
  logic [ALU_OP_W-1:0] alu_op;
  logic                halted;
  logic                illegal;
  logic [CNT_W-1:0]    instr_count;
  modport master (
    input  opcode, acc_zero, mem_ready,
    output mem_read, mem_write, addr_sel, ir_load, mdr_load, pc_inc, pc_load,
           acc_load, alu_op, halted, illegal, instr_count
  );
  modport slave (
    output opcode, acc_zero, mem_ready,
    input  mem_read, mem_write, addr_sel, ir_load, mdr_load, pc_inc, pc_load,
           acc_load, alu_op, halted, illegal, instr_count
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: fetch/decode/memory/execute sequencer for the accumulator datapath
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 3,
  parameter int CNT_W    = 16
) (
  input logic clk,
  input logic reset,
  multicycle_control_if.master bus
);
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             ill_q, ill_d, retire;
  logic [3:0]       op;
  assign op              = 4'(bus.opcode);
  assign bus.illegal     = ill_q;
  assign bus.instr_count = cnt_q;
  assign bus.halted      = state_q == S_HALT;
  always_comb begin
    state_d      = state_q;
    ill_d        = ill_q;
    retire       = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr_sel = 1'b0;
    bus.ir_load  = 1'b0;
    bus.mdr_load = 1'b0;
    bus.pc_inc   = 1'b0;
    bus.pc_load  = 1'b0;
    bus.acc_load = 1'b0;
    bus.alu_op   = '0;
    case (state_q)
      S_FETCH: begin
        bus.mem_read = 1'b1;
        bus.ir_load  = bus.mem_ready;
        bus.pc_inc   = bus.mem_ready;
        state_d      = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        bus.pc_load = op == OP_JMP || (op == OP_JZ && bus.acc_zero);
        retire      = op inside {OP_NOP, OP_JMP, OP_JZ, OP_HALT};
        // anything not recognised falls through to a sticky illegal halt
        ill_d       = ill_q | !(retire || reads_operand(op) || op == OP_STORE);
        state_d     = op == OP_HALT || ill_d ? S_HALT :
                      reads_operand(op) ? S_MEM_RD :
                      op == OP_STORE ? S_MEM_WR : S_FETCH;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.addr_sel = 1'b1;
        bus.mdr_load = bus.mem_ready;
        state_d      = bus.mem_ready ? S_EXEC : S_MEM_RD;
      end
      S_EXEC: begin
        bus.acc_load = 1'b1;
        bus.alu_op   = ALU_OP_W'(alu_of(op));
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.addr_sel  = 1'b1;
        retire        = bus.mem_ready;
        state_d       = bus.mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_q + CNT_W'(retire);
      ill_q   <= ill_d;
    end
  end
endmodule
